// File: rtl/opb_reg_pkg.sv
// Shared types and bus/user bit-order helpers for the PPC-to-Simulink register bank.
package opb_reg_pkg;

  localparam int unsigned OPB_DW    = 32;
  localparam int unsigned OPB_LANES = OPB_DW / 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } ack_state_e;

  // LSB position, in user (descending) order, of the byte covered by byte enable 'lane'.
  // Lane 0 is the most significant byte.
  function automatic int unsigned lane_lsb(input int unsigned lane);
    return OPB_DW - 8 * (lane + 1);
  endfunction

  // OPB bit 0 is the MSB; user bit 31 is the MSB.
  function automatic logic [OPB_DW-1:0] dbus_to_user(input logic [0:OPB_DW-1] d);
    logic [OPB_DW-1:0] u;
    u = '0;
    for (int unsigned i = 0; i < OPB_DW; i++) begin
      u[OPB_DW-1-i] = d[i];
    end
    return u;
  endfunction

  function automatic logic [0:OPB_DW-1] user_to_dbus(input logic [OPB_DW-1:0] u);
    logic [0:OPB_DW-1] d;
    d = '0;
    for (int unsigned i = 0; i < OPB_DW; i++) begin
      d[i] = u[OPB_DW-1-i];
    end
    return d;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave address decode and single-cycle IDLE/ACK handshake.
module opb_slave_ack_fsm
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01080300,
  parameter logic [31:0] C_HIGHADDR   = 32'h010803FF,
  parameter int          C_OPB_AWIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    select,
  input  logic                    rnw,
  input  logic [0:C_OPB_AWIDTH-1] abus,
  output logic                    hit_wr,
  output logic                    hit_rd,
  output logic [C_OPB_AWIDTH-3:0] idx,
  output logic                    xfer_ack
);

  localparam logic [C_OPB_AWIDTH-1:0] BASE = C_BASEADDR[C_OPB_AWIDTH-1:0];
  localparam logic [C_OPB_AWIDTH-1:0] HIGH = C_HIGHADDR[C_OPB_AWIDTH-1:0];

  ack_state_e                state_q, state_d;
  logic [C_OPB_AWIDTH-1:0]   offset;
  logic                      in_window;
  logic                      unused_offset_lsbs;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a window hit in IDLE moves to ACK; ACK always returns to IDLE.
  always_comb begin
    in_window = select && (abus >= BASE) && (abus <= HIGH);
    state_d   = state_q;
    unique case (state_q)
      IDLE:    if (in_window) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: hits are qualified by IDLE so select held through ACK is not re-sampled.
  always_comb begin
    offset             = abus - BASE;
    idx                = offset[C_OPB_AWIDTH-1:2];
    unused_offset_lsbs = ^offset[1:0];
    hit_wr             = (state_q == IDLE) && in_window && !rnw;
    hit_rd             = (state_q == IDLE) && in_window && rnw;
    xfer_ack           = (state_q == ACK);
  end

endmodule

// File: rtl/opb_register_ppc2simulink_bank.sv
// Software-writable register bank: OPB writes with byte enables, readback, per-register update strobes.
module opb_register_ppc2simulink_bank
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01080300,
  parameter logic [31:0] C_HIGHADDR   = 32'h010803FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex6",
  parameter int          C_NUM_REGS   = 4,
  parameter logic [31:0] C_INIT_VALUE = 32'h00000000
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_data_valid
);

  localparam int    IDX_W         = C_OPB_AWIDTH - 2;
  localparam string unused_family = C_FAMILY;

  logic [OPB_DW-1:0]   regs_q  [C_NUM_REGS];
  logic [OPB_DW-1:0]   regs_d  [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] valid_q, valid_d;
  logic [0:OPB_DW-1]   sl_dbus_q, sl_dbus_d;
  logic [OPB_DW-1:0]   wr_user;
  logic                hit_wr, hit_rd;
  logic [IDX_W-1:0]    idx;
  logic                unused_seq;

  opb_slave_ack_fsm #(
    .C_BASEADDR  (C_BASEADDR),
    .C_HIGHADDR  (C_HIGHADDR),
    .C_OPB_AWIDTH(C_OPB_AWIDTH)
  ) u_ack_fsm (
    .clk     (OPB_Clk),
    .rst     (OPB_Rst),
    .select  (OPB_select),
    .rnw     (OPB_RNW),
    .abus    (OPB_ABus),
    .hit_wr  (hit_wr),
    .hit_rd  (hit_rd),
    .idx     (idx),
    .xfer_ack(Sl_xferAck)
  );

  // Byte-enable merge, update strobe and read mux; out-of-range indices match no register.
  always_comb begin
    regs_d    = regs_q;
    valid_d   = '0;
    sl_dbus_d = '0;
    wr_user   = dbus_to_user(OPB_DBus);
    for (int unsigned k = 0; k < C_NUM_REGS; k++) begin
      if (idx == IDX_W'(k)) begin
        if (hit_wr) begin
          for (int unsigned b = 0; b < OPB_LANES; b++) begin
            if (OPB_BE[b]) begin
              regs_d[k][lane_lsb(b) +: 8] = wr_user[lane_lsb(b) +: 8];
            end
          end
          valid_d[k] = 1'b1;
        end
        if (hit_rd) begin
          sl_dbus_d = user_to_dbus(regs_q[k]);
        end
      end
    end
  end

  // Register array, strobes and read data update on the IDLE->ACK edge.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int unsigned k = 0; k < C_NUM_REGS; k++) begin
        regs_q[k] <= C_INIT_VALUE;
      end
      valid_q   <= '0;
      sl_dbus_q <= '0;
    end else begin
      regs_q    <= regs_d;
      valid_q   <= valid_d;
      sl_dbus_q <= sl_dbus_d;
    end
  end

  // Flatten registers onto the user bus and tie off unused OPB responses.
  always_comb begin
    user_data_out = '0;
    for (int unsigned k = 0; k < C_NUM_REGS; k++) begin
      user_data_out[32*k +: 32] = regs_q[k];
    end
    user_data_valid = valid_q;
    Sl_DBus         = sl_dbus_q;
    Sl_errAck       = 1'b0;
    Sl_retry        = 1'b0;
    Sl_toutSup      = 1'b0;
    unused_seq      = OPB_seqAddr;
  end

endmodule
